wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning MDU result buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive pipeline wins before a forced MDU grant (used only with WB_ARB_FAIR_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_pipe_we  input  1  pipeline WB-stage write request.
REQ-006 SHALL have port i_pipe_rd  input  5  pipeline destination register.
REQ-007 SHALL have port i_pipe_data  input  32  pipeline write data.
REQ-008 SHALL have port i_mdu_valid  input  1  multi-cycle unit result valid.
REQ-009 SHALL have port i_mdu_rd  input  5  MDU destination register.
REQ-010 SHALL have port i_mdu_data  input  32  MDU result.
REQ-011 SHALL have port o_mdu_ready  output  1  buffer can accept MDU result.
REQ-012 SHALL have port o_rf_we  output  1  register-file write enable.
REQ-013 SHALL have port o_rf_rd  output  5  register-file write address.
REQ-014 SHALL have port o_rf_data  output  32  register-file write data.
REQ-015 SHALL have port o_pipe_stall  output  1  pipeline must hold WB inputs this cycle.
REQ-016 SHALL have port o_pend_cnt  output  $clog2(FIFO_DEPTH)+1  buffered MDU results.

Function
REQ-017 SHALL transfer an MDU result when i_mdu_valid && o_mdu_ready at a rising edge; o_mdu_ready = buffer not full, independent of i_mdu_valid.
REQ-018 SHALL accept but not store MDU results with i_mdu_rd == 0.
REQ-019 SHALL treat pipeline requests with i_pipe_rd == 0 as no request.
REQ-020 SHALL grant per cycle: forced-MDU (REQ-029) > pipeline request > buffer head > idle.
REQ-021 SHALL register the granted rd/data into o_rf_we/o_rf_rd/o_rf_data: one-cycle latency; o_rf_we = 0 when idle, o_rf_rd/o_rf_data hold last value.
REQ-022 SHALL pop the buffer head in the cycle it is granted.
REQ-023 SHALL discard the buffer head (pop without write) when the pipeline is granted with i_pipe_rd equal to the head rd (WAW supersede); only the head is checked.
REQ-024 SHALL allow push and pop in the same cycle, including when full at cycle start (ready was 0, so no push occurs); o_pend_cnt is updated accordingly.
REQ-025 SHALL wrap buffer pointers modulo FIFO_DEPTH, FIFO order preserved.
REQ-026 SHALL never assert o_rf_we for rd 0.

Reset
REQ-027 SHALL, while rst = 1, asynchronously clear the buffer (o_pend_cnt = 0), o_mdu_ready = 1, o_rf_we = 0, o_rf_rd = 0, o_rf_data = 0, o_pipe_stall = 0, starvation counter = 0.
REQ-028 SHALL discard buffered entries on reset mid-operation; no write is issued in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with macro WB_ARB_FAIR_EN defined, keep a starvation counter incremented each cycle the pipeline is granted while the buffer is non-empty, cleared on an MDU grant or empty buffer; when it equals STARVE_LIMIT, o_pipe_stall = 1 (combinational), the head is granted, the pipeline request is ignored that cycle, and the counter clears.
REQ-030 SHALL, without WB_ARB_FAIR_EN, tie o_pipe_stall to 0 and omit the counter; the pipeline always wins.

Verification
REQ-031 SHALL cover: MDU rd=5 data=0xA5 pushed, no pipeline request -> next cycle o_rf_we=1, o_rf_rd=5, o_rf_data=0xA5, o_pend_cnt back to 0.
REQ-032 SHALL cover: pipeline rd=3 each cycle while 2 MDU results pushed -> o_mdu_ready=0 after 2 pushes; MDU writes follow in FIFO order once pipeline idles.
REQ-033 SHALL cover: head rd=7, pipeline writes rd=7 data=0x11 -> only 0x11 written to r7, head dropped, o_pend_cnt decrements.
REQ-034 SHALL cover: MDU rd=0 pushed and pipeline rd=0 request -> o_rf_we stays 0, o_pend_cnt stays 0.
REQ-035 SHALL cover: WB_ARB_FAIR_EN, STARVE_LIMIT=4, continuous pipeline rd=1 with one buffered MDU rd=9 -> o_pipe_stall=1 in the 5th cycle and r9 written the following cycle; without the macro, r9 is never written.
REQ-036 SHALL cover: rst asserted with 2 buffered entries -> o_pend_cnt=0 and o_rf_we=0 immediately, no stale write after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// ----------------
// Arbitrates the register-file write port between the in-order pipeline
// write-back stage and a multi-cycle unit (MDU). MDU results that cannot be
// written immediately are held in a small FIFO and drained when the
// pipeline leaves the write port free. A registered write port gives a
// one-cycle latency from grant to o_rf_we.
//
// Optional feature (macro WB_ARB_FAIR_EN):
//   When defined, a starvation counter forces an MDU grant after
//   STARVE_LIMIT consecutive pipeline wins over a non-empty buffer. In that
//   cycle o_pipe_stall is raised so the pipeline holds its WB inputs.
//   When undefined, the pipeline always wins and o_pipe_stall is tied to 0.
//
// Parameters:
//   FIFO_DEPTH   - MDU result buffer entries (power of two, >= 2)
//   STARVE_LIMIT - pipeline wins before a forced MDU grant (fair mode only)
//
// Ports:
//   clk, rst                              - clock, async active-high reset
//   i_pipe_we/i_pipe_rd/i_pipe_data       - pipeline write request
//   i_mdu_valid/i_mdu_rd/i_mdu_data       - MDU result (handshake with o_mdu_ready)
//   o_mdu_ready                           - buffer not full
//   o_rf_we/o_rf_rd/o_rf_data             - registered register-file write port
//   o_pipe_stall                          - pipeline must hold WB inputs
//   o_pend_cnt                            - number of buffered MDU results

module wb_port_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_pipe_we,
    input  logic [4:0]                      i_pipe_rd,
    input  logic [31:0]                     i_pipe_data,
    input  logic                            i_mdu_valid,
    input  logic [4:0]                      i_mdu_rd,
    input  logic [31:0]                     i_mdu_data,
    output logic                            o_mdu_ready,
    output logic                            o_rf_we,
    output logic [4:0]                      o_rf_rd,
    output logic [31:0]                     o_rf_data,
    output logic                            o_pipe_stall,
    output logic [$clog2(FIFO_DEPTH):0]     o_pend_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Buffer storage: no reset needed, validity is tracked by cnt_reg.
    logic [4:0]    rd_mem   [FIFO_DEPTH];
    logic [31:0]   data_mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          rf_we_reg;
    logic [4:0]    rf_rd_reg;
    logic [31:0]   rf_data_reg;

    logic          head_valid;
    logic          full;
    logic          push;
    logic          pop;
    logic          pipe_req;
    logic          forced;
    logic          mdu_gnt;
    logic          pipe_gnt;
    logic          wr_en;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign head_valid = (cnt_reg != '0);
    assign full       = (cnt_reg == CW'(FIFO_DEPTH));
    assign head_rd    = rd_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    // Ready depends only on occupancy so the MDU can rely on it before
    // deciding to present a result.
    assign o_mdu_ready = !full;

    // Results for r0 complete the handshake but are never stored.
    assign push     = i_mdu_valid && !full && (i_mdu_rd != 5'd0);
    assign pipe_req = i_pipe_we && (i_pipe_rd != 5'd0);

`ifdef WB_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_reg;

    // head_valid guard keeps a stale count from stalling with nothing to drain.
    assign forced       = head_valid && (starve_reg == SW'(STARVE_LIMIT));
    assign o_pipe_stall = forced;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
        end else if (mdu_gnt || !head_valid) begin
            starve_reg <= '0;
        end else if (pipe_gnt) begin
            starve_reg <= starve_reg + SW'(1);
        end
    end
`else
    logic unused_fair;

    assign forced       = 1'b0;
    assign o_pipe_stall = 1'b0;
    assign unused_fair  = ^{mdu_gnt, pipe_gnt, (STARVE_LIMIT != 0)};
`endif

    // Grant priority: forced MDU > pipeline > buffer head > idle.
    always_comb begin
        wr_en    = 1'b0;
        wr_rd    = head_rd;
        wr_data  = head_data;
        pop      = 1'b0;
        mdu_gnt  = 1'b0;
        pipe_gnt = 1'b0;
        if (forced) begin
            wr_en   = 1'b1;
            pop     = 1'b1;
            mdu_gnt = 1'b1;
        end else if (pipe_req) begin
            wr_en    = 1'b1;
            wr_rd    = i_pipe_rd;
            wr_data  = i_pipe_data;
            pipe_gnt = 1'b1;
            // A newer pipeline write to the same register makes the head
            // result obsolete; drop it instead of writing it later.
            pop      = head_valid && (head_rd == i_pipe_rd);
        end else if (head_valid) begin
            wr_en   = 1'b1;
            pop     = 1'b1;
            mdu_gnt = 1'b1;
        end
    end

    assign cnt_next = cnt_reg + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= i_mdu_rd;
            data_mem[wr_ptr_reg] <= i_mdu_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            cnt_reg <= cnt_next;
        end
    end

    // Write address/data hold their last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_reg   <= 1'b0;
            rf_rd_reg   <= '0;
            rf_data_reg <= '0;
        end else begin
            rf_we_reg <= wr_en;
            if (wr_en) begin
                rf_rd_reg   <= wr_rd;
                rf_data_reg <= wr_data;
            end
        end
    end

    assign o_rf_we    = rf_we_reg;
    assign o_rf_rd    = rf_rd_reg;
    assign o_rf_data  = rf_data_reg;
    assign o_pend_cnt = cnt_reg;

endmodule
